// File: rtl/bin_win3x3_gen.sv
// 3x3 binary window generator: two internal 1-bit line buffers plus a 3-column shift register.
// Two-cycle latency from in_de/in_bit to out_de/win.
module bin_win3x3_gen #(
    parameter int unsigned IMG_WIDTH_LINE = 1024,
    parameter int unsigned ADDR_W         = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_vsync,
    input  logic       in_de,
    input  logic       in_bit,
    output logic       out_vsync,
    output logic       out_de,
    output logic [8:0] win
);

    localparam int unsigned RamAw = (IMG_WIDTH_LINE > 1) ? $clog2(IMG_WIDTH_LINE) : 1;
    localparam logic [ADDR_W-1:0] ColMax = ADDR_W'(IMG_WIDTH_LINE - 1);

    logic lb0_mem [IMG_WIDTH_LINE];
    logic lb1_mem [IMG_WIDTH_LINE];

    logic [ADDR_W-1:0] col_q, col_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        row_q, row_d;

    // Stage 1 (t+1)
    logic             vs1_q, vs1_d, de1_q, de1_d, bit1_q, bit1_d;
    logic             wen1_q, wen1_d, ovf1_q, ovf1_d, rd0_q, rd0_d, rd1_q, rd1_d;
    logic [1:0]       row1_q, row1_d;
    logic [RamAw-1:0] addr1_q, addr1_d;

    // Stage 2 (t+2): col0 is the newest column, each vector is {top, mid, bot}
    logic       vs2_q, vs2_d, de2_q, de2_d, ovf2_q, ovf2_d;
    logic [2:0] col0_q, col0_d, col1_q, col1_d, col2_q, col2_d;

    logic              vs_rise, de_fall, ovf_cur, wen0;
    logic [1:0]        row_cur;
    logic [ADDR_W-1:0] addr;
    logic [RamAw-1:0]  addr_r;
    logic [2:0]        colv;

    always_comb begin
        vs_rise = in_vsync & ~vs1_q;
        de_fall = ~in_de & de1_q;
        // A pixel arriving with the vsync edge is column 0, row 0 of the new frame
        addr    = vs_rise ? '0 : col_q;
        ovf_cur = vs_rise ? 1'b0 : ovf_q;
        row_cur = vs_rise ? 2'd0 : row_q;
        addr_r  = addr[RamAw-1:0];
        wen0    = in_de & ~ovf_cur;

        col_d = '0;
        ovf_d = 1'b0;
        if (in_de) begin
            if (addr == ColMax) begin
                col_d = ColMax;
                ovf_d = 1'b1;
            end else begin
                col_d = addr + 1'b1;
            end
        end

        row_d = row_q;
        if (vs_rise) begin
            row_d = 2'd0;
        end else if (de_fall && row_q != 2'd2) begin
            row_d = row_q + 2'd1;
        end

        vs1_d   = in_vsync;
        de1_d   = in_de;
        bit1_d  = in_bit;
        wen1_d  = wen0;
        ovf1_d  = in_de & ovf_cur;
        row1_d  = row_cur;
        addr1_d = addr_r;
        rd0_d   = lb0_mem[addr_r];
        rd1_d   = lb1_mem[addr_r];

        colv = {rd1_q & (row1_q == 2'd2) & ~ovf1_q,
                rd0_q & (row1_q != 2'd0) & ~ovf1_q,
                bit1_q};

        vs2_d  = vs1_q;
        de2_d  = de1_q;
        ovf2_d = de1_q & ovf1_q;
        col0_d = '0;
        col1_d = '0;
        col2_d = '0;
        if (de1_q) begin
            col0_d = colv;
            col1_d = col0_q;
            col2_d = col1_q;
        end

        win = {col2_q[2], col1_q[2], col0_q[2],
               col2_q[1], col1_q[1], col0_q[1],
               col2_q[0], col1_q[0], col0_q[0]};
        // Saturated pixels have no valid history, so their upper rows are blanked
        if (ovf2_q) begin
            win[8:3] = '0;
        end
    end

    assign out_vsync = vs2_q;
    assign out_de    = de2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            ovf_q   <= 1'b0;
            row_q   <= 2'd0;
            vs1_q   <= 1'b0;
            de1_q   <= 1'b0;
            bit1_q  <= 1'b0;
            wen1_q  <= 1'b0;
            ovf1_q  <= 1'b0;
            row1_q  <= 2'd0;
            addr1_q <= '0;
            rd0_q   <= 1'b0;
            rd1_q   <= 1'b0;
            vs2_q   <= 1'b0;
            de2_q   <= 1'b0;
            ovf2_q  <= 1'b0;
            col0_q  <= '0;
            col1_q  <= '0;
            col2_q  <= '0;
        end else begin
            col_q   <= col_d;
            ovf_q   <= ovf_d;
            row_q   <= row_d;
            vs1_q   <= vs1_d;
            de1_q   <= de1_d;
            bit1_q  <= bit1_d;
            wen1_q  <= wen1_d;
            ovf1_q  <= ovf1_d;
            row1_q  <= row1_d;
            addr1_q <= addr1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            vs2_q   <= vs2_d;
            de2_q   <= de2_d;
            ovf2_q  <= ovf2_d;
            col0_q  <= col0_d;
            col1_q  <= col1_d;
            col2_q  <= col2_d;
        end
    end

    // Line storage is not reset; row masking hides stale contents
    always_ff @(posedge clk) begin
        if (wen0) begin
            lb0_mem[addr_r] <= in_bit;
        end
        if (wen1_q) begin
            lb1_mem[addr1_q] <= rd0_q;
        end
    end

endmodule
